// File: rtl/clink_rec_pkg.sv
// rtl/clink_rec_pkg.sv - shared state encoding for the Clink REC sequencer
package clink_rec_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        I_RECV = 3'd1,
        G_RECV = 3'd2,
        F_RECV = 3'd3,
        O_RECV = 3'd4,
        C_RECV = 3'd5,
        FINISH = 3'd6
    } rec_state_e;

endpackage

// File: rtl/clink_rec_dwell_cnt.sv
// rtl/clink_rec_dwell_cnt.sv - saturating F-phase dwell counter
module clink_rec_dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [DWELL_W-1:0] limit,
    output logic [DWELL_W-1:0] count,
    output logic               at_limit
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count < limit) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/clink_rec_seq.sv
// rtl/clink_rec_seq.sv - I/G/F/O/C recurrence sequencer with LUT address select
module clink_rec_seq
    import clink_rec_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int ITER_W  = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ITER_W-1:0]  cfg_iters,
    input  logic [DWELL_W-1:0] cfg_f_dwell,
    input  logic               step_ready,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ITER_W-1:0]  iter_n,
    output logic [STATE_W-1:0] curr_s,
    input  logic [ADDR_W-1:0]  lut_mvm_addr,
    input  logic [ADDR_W-1:0]  lut_rec_addr,
    output logic [ADDR_W-1:0]  lut_addr
);

    rec_state_e         state_q, state_d;
    logic [ITER_W-1:0]  iter_n_q, iter_n_d, iter_inc;
    logic [ITER_W-1:0]  iters_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_count;
    logic               dwell_done;
    logic               accept_start;
    logic               take_abort;
    logic               aborted_q;

    // Counter is held clear outside F so it always starts from zero on entry.
    clink_rec_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (state_q != F_RECV),
        .limit    (dwell_q),
        .count    (dwell_count),
        .at_limit (dwell_done)
    );

    assign iter_inc     = iter_n_q + 1'b1;
    assign accept_start = (state_q == IDLE) && start;
    assign take_abort   = (state_q != IDLE) && abort;

    always_comb begin
        state_d  = state_q;
        iter_n_d = iter_n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    iter_n_d = '0;
                    state_d  = (cfg_iters == '0) ? FINISH : I_RECV;
                end
            end
            I_RECV: if (step_ready) state_d = G_RECV;
            G_RECV: if (step_ready) state_d = F_RECV;
            F_RECV: if (step_ready && dwell_done) state_d = O_RECV;
            O_RECV: if (step_ready) state_d = C_RECV;
            C_RECV: begin
                if (step_ready) begin
                    iter_n_d = iter_inc;
                    state_d  = (iter_inc == iters_q) ? FINISH : I_RECV;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every exit, including the final C to FINISH step.
        if (take_abort) begin
            state_d  = IDLE;
            iter_n_d = iter_n_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            iter_n_q  <= '0;
            iters_q   <= '0;
            dwell_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_n_q  <= iter_n_d;
            aborted_q <= take_abort;
            if (accept_start) begin
                iters_q <= cfg_iters;
                dwell_q <= cfg_f_dwell;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign aborted  = aborted_q;
    assign iter_n   = iter_n_q;
    assign curr_s   = state_q;
    assign lut_addr = (state_q == F_RECV) ? lut_rec_addr : lut_mvm_addr;

endmodule
